// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin packet arbiter and flit sequencer for one router output port
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module output_port_arbiter #(
  parameter int NPORTS      = 5,
  parameter int WIDTH       = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       req,
  input  logic [NPORTS-1:0]       nonempty,
  input  logic [NPORTS*WIDTH-1:0] heads,
  input  logic                    credit_i,
  output logic [NPORTS-1:0]       pull,
  output logic [WIDTH-1:0]        tx_o,
  output logic                    tx_valid_o,
  output logic [NPORTS-1:0]       grant_o,
  output logic                    busy_o,
  output logic                    stall_err_o
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, HDR, SIZE, PAYLOAD} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     arb_idx;
  logic              arb_found;
  logic [WIDTH-1:0]  remaining;
  logic              transfer;
  logic              wd_fire;

  assign busy_o     = (state != IDLE);
  assign tx_valid_o = (state != IDLE) && |(nonempty & grant_o);
  assign transfer   = tx_valid_o && credit_i;
  assign pull       = grant_o & {NPORTS{transfer}};

  always_comb begin
    tx_o = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_o[i]) tx_o = tx_o | heads[i*WIDTH +: WIDTH];
    end
  end

  // Scan starts one past the pointer, so the last owner has lowest priority.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      grant_o   <= '0;
      grant_idx <= '0;
      ptr       <= PW'(NPORTS - 1);
      remaining <= '0;
    end else if (wd_fire) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= grant_idx;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_o   <= NPORTS'(1) << arb_idx;
            grant_idx <= arb_idx;
            state     <= HDR;
          end
        end
        HDR: begin
          if (transfer) state <= SIZE;
        end
        SIZE: begin
          if (transfer) begin
            remaining <= tx_o;
            if (tx_o == '0) begin
              state   <= IDLE;
              grant_o <= '0;
              ptr     <= grant_idx;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (transfer) begin
            remaining <= remaining - 1'b1;
            if (remaining == WIDTH'(1)) begin
              state   <= IDLE;
              grant_o <= '0;
              ptr     <= grant_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] stall_cnt;

  // Fires on the STALL_LIMIT-th consecutive stalled cycle.
  assign wd_fire = (state != IDLE) && !transfer && (stall_cnt == CW'(STALL_LIMIT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt   <= '0;
      stall_err_o <= 1'b0;
    end else if (state == IDLE || transfer) begin
      stall_cnt <= '0;
    end else if (wd_fire) begin
      stall_cnt   <= '0;
      stall_err_o <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_stall_limit;

  assign unused_stall_limit = ^STALL_LIMIT;
  assign wd_fire            = 1'b0;
  assign stall_err_o        = 1'b0;
`endif

endmodule
